script_runner: RTL

- Upstream sequencer for the action decoder stage.
- Fetches 16-bit script words from a synchronous script ROM and decodes them.
- Drives en / i_num / func to the action stage and watches the kitchen feedback byte to decide when each step is complete.
- Provides delays, feedback-conditioned waits, conditional jumps and a watchdog timeout, so a whole recipe runs unattended from one start pulse.

---
 rtl/script_runner.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/script_runner.sv
// Script sequencer: fetches 16-bit words from a synchronous ROM and drives
// the action stage with en/i_num/func, handling waits, jumps and a watchdog.
module script_runner #(
    parameter int ADDR_W         = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] script_addr,
    input  logic [15:0]       script_data,
    input  logic [7:0]        feedbak_sig,
    output logic              en,
    output logic [7:0]        i_num,
    output logic [1:0]        func,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = (TO_W > 12) ? TO_W : 12;
    localparam int ST_N = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(ST_N);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        ACT_MOVE,
        ACT_DO,
        SETTLE,
        WAIT_CNT,
        WAIT_SIG,
        DONE
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] sig_sel;
    logic sig_val;
    logic jmp_take;
    logic sig_hit;
    logic [ADDR_W-1:0] pc_inc;

    // script_addr doubles as the program counter
    assign pc_inc = script_addr + ADDR_W'(1);
    assign sig_hit = (feedbak_sig[sig_sel] == sig_val);

    always_comb begin
        jmp_take = 1'b0;
        unique case (script_data[13:12])
            2'b00: jmp_take = 1'b1;
            2'b01: jmp_take = feedbak_sig[0];
            2'b10: jmp_take = ~feedbak_sig[0];
            2'b11: jmp_take = feedbak_sig[3];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            script_addr <= '0;
            cnt         <= '0;
            sig_sel     <= '0;
            sig_val     <= 1'b0;
            en          <= 1'b0;
            i_num       <= '0;
            func        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else if (stop) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        done        <= 1'b0;
                        err         <= 1'b0;
                        script_addr <= '0;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    unique case (script_data[15:14])
                        2'b00: begin
                            i_num <= script_data[7:0];
                            func  <= script_data[13:12];
                            en    <= 1'b1;
                            cnt   <= '0;
                            state <= ACT_MOVE;
                        end
                        2'b01: begin
                            if (script_data[13]) begin
                                sig_sel <= script_data[10:8];
                                sig_val <= script_data[12];
                                cnt     <= '0;
                                state   <= WAIT_SIG;
                            end else if (script_data[11:0] == 12'd0) begin
                                script_addr <= pc_inc;
                                state       <= FETCH;
                            end else begin
                                cnt   <= CW'(script_data[11:0]);
                                state <= WAIT_CNT;
                            end
                        end
                        2'b10: begin
                            script_addr <= jmp_take ?
                                ADDR_W'(script_data[7:0]) : pc_inc;
                            state <= FETCH;
                        end
                        2'b11: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            en    <= 1'b0;
                            state <= DONE;
                        end
                    endcase
                end
                ACT_MOVE: begin
                    if (feedbak_sig[2]) begin
                        state <= ACT_DO;
                    end else if (cnt == TO_LAST) begin
                        err   <= 1'b1;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ACT_DO: begin
                    en          <= 1'b0;
                    script_addr <= pc_inc;
                    cnt         <= '0;
                    state       <= (SETTLE_CYCLES == 0) ? FETCH : SETTLE;
                end
                SETTLE: begin
                    if (cnt == ST_LAST) state <= FETCH;
                    else cnt <= cnt + ONE;
                end
                WAIT_CNT: begin
                    if (cnt == ONE) begin
                        script_addr <= pc_inc;
                        state       <= FETCH;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                WAIT_SIG: begin
                    if (sig_hit) begin
                        script_addr <= pc_inc;
                        state       <= FETCH;
                    end else if (cnt == TO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
